// File: rtl/nibble_serial_adder_if.sv
// Operand/result bundle for nibble_serial_adder.
//   master : operand source (drives start/a/b/cin, observes status and result)
//   slave  : the adder itself
// Signals:
//   start     request to capture a, b, cin and begin an add
//   a, b      W-bit operands, W = 4*NIBBLES
//   cin       carry into nibble 0
//   busy      nibbles are being processed
//   done      one-cycle pulse, sum/cout/overflow valid
//   sum       result, held until the next accepted start
//   cout      carry out of the MSB
//   overflow  signed overflow of the W-bit add
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle W-bit adder (W = 4*NIBBLES) built around one 4-bit
//   add-with-carry step. One nibble is added per clock, LSB nibble first; the
//   carry between nibbles lives in a register so no carry chain is wider than
//   a nibble.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset, aborts any add in progress
//   bus  nibble_serial_adder_if.slave (start/a/b/cin in, busy/done/sum/cout/
//        overflow out)
// Timing: start sampled at edge 0 -> busy after edges 0..NIBBLES-1, done and
//   final sum after edge NIBBLES. A start during the done cycle is accepted
//   directly, so back-to-back adds need no idle cycle. sum shows the partial
//   result while busy; consumers qualify it with done.

// One 4-bit add-with-carry step. c3 is the carry into bit 3, needed for the
// signed-overflow flag when this is the most significant nibble.
module nibble_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);
    logic [4:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
        s    = full[3:0];
        co   = full[4];
        // Sum bit = a ^ b ^ carry-in, so the carry-in can be recovered.
        c3   = a[3] ^ b[3] ^ full[3];
    end
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    nibble_serial_adder_if.slave  bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Operands and result kept as nibble arrays so the step index selects
    // one nibble directly.
    logic [NIBBLES-1:0][3:0] a_q;
    logic [NIBBLES-1:0][3:0] b_q;
    logic [NIBBLES-1:0][3:0] sum_q;
    logic                    carry_q;
    logic [IW-1:0]           idx_q;
    logic                    cout_q;
    logic                    ovf_q;

    logic [3:0] step_s;
    logic       step_co;
    logic       step_c3;
    logic       last_step;
    logic       accept;

    assign last_step = (idx_q == LAST_IDX);
    // start is honoured in IDLE and in the done cycle; RUN ignores it.
    assign accept    = bus.start && (state == IDLE || state == DONE);

    nibble_add4 u_step (
        .a  (a_q[idx_q]),
        .b  (b_q[idx_q]),
        .ci (carry_q),
        .s  (step_s),
        .co (step_co),
        .c3 (step_c3)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode, straight from the registered state
    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == DONE);
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state == RUN) begin
            sum_q[idx_q] <= step_s;
            carry_q      <= step_co;
            idx_q        <= idx_q + 1'b1;
            if (last_step) begin
                cout_q <= step_co;
                ovf_q  <= step_c3 ^ step_co;
            end
        end
    end

    assign bus.sum      = W'(sum_q);
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_if #(.NIBBLES(4)) bus ();

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Issues one start at a negedge and waits (bounded) for done.
    // Returns at the negedge where done is high; counts busy cycles seen.
    task automatic run_add(input logic [15:0] ta, input logic [15:0] tbv,
                           input logic tc, output int bcyc, output bit got_done);
        @(negedge clk);
        bus.start = 1'b1; bus.a = ta; bus.b = tbv; bus.cin = tc;
        @(negedge clk);
        bus.start = 1'b0;
        bcyc = 0; got_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.done) begin got_done = 1'b1; break; end
            if (bus.busy) bcyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.busy, bus.done, bus.sum, bus.cout, bus.overflow} !== 19'd0) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.overflow);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int bc; bit gd;
        run_add(16'h0001, 16'h0000, 1'b0, bc, gd);
        total++;
        if (gd !== 1'b1 || bc != 4) begin
            bad++; $display("FAIL basic_latency: done=%b busy_cycles=%0d want 1/4", gd, bc);
        end
        total++;
        if (bus.sum !== 16'h0001 || bus.cout !== 1'b0 || bus.overflow !== 1'b0) begin
            bad++; $display("FAIL basic_result: sum=%h c=%b o=%b want 0001/0/0",
                            bus.sum, bus.cout, bus.overflow);
        end
        @(negedge clk);
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.sum !== 16'h0001) begin
            bad++; $display("FAIL basic_pulse: done=%b busy=%b sum=%h want 0/0/0001",
                            bus.done, bus.busy, bus.sum);
        end
    endtask

    task automatic test_carry_out();
        int bc; bit gd;
        run_add(16'hFFFF, 16'h0001, 1'b0, bc, gd);
        total++;
        if (gd !== 1'b1 || bc != 4) begin
            bad++; $display("FAIL carry_busy: done=%b busy_cycles=%0d want 1/4", gd, bc);
        end
        total++;
        if (bus.sum !== 16'h0000 || bus.cout !== 1'b1 || bus.overflow !== 1'b0) begin
            bad++; $display("FAIL carry_result: sum=%h c=%b o=%b want 0000/1/0",
                            bus.sum, bus.cout, bus.overflow);
        end
    endtask

    task automatic test_overflow();
        int bc; bit gd;
        run_add(16'h7FFF, 16'h0001, 1'b0, bc, gd);
        total++;
        if (gd !== 1'b1 || bus.sum !== 16'h8000 || bus.cout !== 1'b0 || bus.overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_pos: done=%b sum=%h c=%b o=%b want 1/8000/0/1",
                            gd, bus.sum, bus.cout, bus.overflow);
        end
        run_add(16'h8000, 16'h8000, 1'b0, bc, gd);
        total++;
        if (gd !== 1'b1 || bus.sum !== 16'h0000 || bus.cout !== 1'b1 || bus.overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_neg: done=%b sum=%h c=%b o=%b want 1/0000/1/1",
                            gd, bus.sum, bus.cout, bus.overflow);
        end
    endtask

    task automatic test_back_to_back();
        bit gd;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h0FED; bus.cin = 1'b1;
        @(negedge clk);
        // In RUN now: a start here must be ignored.
        bus.a = 16'hFFFF; bus.b = 16'h0000; bus.cin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        gd = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.done) begin gd = 1'b1; break; end
            @(negedge clk);
        end
        total++;
        if (gd !== 1'b1 || bus.sum !== 16'h2222 || bus.cout !== 1'b0) begin
            bad++; $display("FAIL ignore_start: done=%b sum=%h c=%b want 1/2222/0",
                            gd, bus.sum, bus.cout);
        end
        // Accept a new add in the done cycle.
        bus.start = 1'b1; bus.a = 16'h0003; bus.b = 16'h0004; bus.cin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            bad++; $display("FAIL b2b_accept: busy=%b done=%b want 1/0", bus.busy, bus.done);
        end
        repeat (3) @(negedge clk);
        total++;
        if (bus.busy !== 1'b1) begin
            bad++; $display("FAIL b2b_busy: busy=%b want 1 at step 4", bus.busy);
        end
        @(negedge clk);
        total++;
        if (bus.done !== 1'b1 || bus.sum !== 16'h0007 || bus.cout !== 1'b0 || bus.overflow !== 1'b0) begin
            bad++; $display("FAIL b2b_result: done=%b sum=%h c=%b o=%b want 1/0007/0/0",
                            bus.done, bus.sum, bus.cout, bus.overflow);
        end
    endtask

    task automatic test_reset_abort();
        int bc; bit gd; bit spur;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.busy !== 1'b1 || bus.sum === 16'h0000) begin
            bad++; $display("FAIL abort_partial: busy=%b sum=%h want 1/nonzero", bus.busy, bus.sum);
        end
        rst = 1'b1;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== 16'h0000) begin
            bad++; $display("FAIL abort_reset: busy=%b done=%b sum=%h want 0/0/0000",
                            bus.busy, bus.done, bus.sum);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        spur = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) spur = 1'b1;
        end
        total++;
        if (spur !== 1'b0) begin
            bad++; $display("FAIL abort_idle: activity after reset=%b want 0", spur);
        end
        run_add(16'h4321, 16'h1234, 1'b0, bc, gd);
        total++;
        if (gd !== 1'b1 || bc != 4 || bus.sum !== 16'h5555 || bus.cout !== 1'b0) begin
            bad++; $display("FAIL abort_new: done=%b busy=%0d sum=%h c=%b want 1/4/5555/0",
                            gd, bc, bus.sum, bus.cout);
        end
    endtask

    task automatic test_sweep();
        int bc; bit gd;
        logic [15:0] ta, tbv, esum;
        logic [16:0] full;
        logic        ec, eo;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int c = 0; c < 2; c++) begin
                    // Upper nibbles chosen so a nibble-0 carry ripples all the
                    // way up; 7FF exercises positive overflow.
                    ta   = {(((x + y) % 2) == 1) ? 12'h7FF : 12'hFFF, 4'(x)};
                    tbv  = {12'h000, 4'(y)};
                    full = {1'b0, ta} + {1'b0, tbv} + 17'(c);
                    esum = full[15:0];
                    ec   = full[16];
                    eo   = (ta[15] == tbv[15]) && (esum[15] != ta[15]);
                    run_add(ta, tbv, 1'(c), bc, gd);
                    total++;
                    if (gd !== 1'b1 || bus.sum !== esum || bus.cout !== ec || bus.overflow !== eo) begin
                        bad++;
                        $display("FAIL sweep a=%h b=%h cin=%0d: done=%b sum=%h c=%b o=%b want 1/%h/%b/%b",
                                 ta, tbv, c, gd, bus.sum, bus.cout, bus.overflow, esum, ec, eo);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_out();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
